// File: rtl/rt_pkg.sv
// Shared types for the racetrack track controller.
//   rt_state_e : top-level access FSM states
//   rt_phase_e : three phases of every current pulse
//   rt_kind_e  : which pulse line a pulse drives
//   rt_dir_e   : shift direction (cell current_s)
package rt_pkg;

  localparam int unsigned PULSES_PER_OP = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ACCESS,
    ST_STEP,
    ST_DONE
  } rt_state_e;

  typedef enum logic [$clog2(PULSES_PER_OP)-1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } rt_phase_e;

  typedef enum logic [1:0] {
    KIND_SHIFT,
    KIND_WRITE,
    KIND_READ
  } rt_kind_e;

  typedef enum logic {
    RT_FWD = 1'b0,
    RT_BWD = 1'b1
  } rt_dir_e;

endpackage

// File: rtl/rt_track_ctrl_if.sv
// Core-side word access bus of the racetrack controller.
//   req_i/we_i/addr_i/wdata_i : request from the core (master drives)
//   gnt_o/rvalid_o/rdata_o/busy_o : response from the controller (slave drives)
interface rt_track_ctrl_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) ();

  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, busy_o
  );

endinterface

// File: rtl/rt_pulse_seq.sv
// Three-phase current pulse generator (SETUP / PULSE / HOLD).
//   start/kind/dir/wbit : launch a pulse; accepted when idle or in HOLD
//   done_c              : high during the HOLD cycle of the current pulse
//   rt_shift/rt_we/rt_read : registered pulse lines, one high in PULSE only
//   rt_dir/rt_wdata     : registered, stable from SETUP through HOLD
module rt_pulse_seq
  import rt_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     start,
  input  rt_kind_e kind,
  input  rt_dir_e  dir,
  input  logic     wbit,
  output logic     done_c,
  output logic     rt_shift,
  output logic     rt_dir,
  output logic     rt_we,
  output logic     rt_wdata,
  output logic     rt_read
);

  logic      active_q, active_d;
  rt_phase_e phase_q, phase_d;
  rt_kind_e  kind_q, kind_d;
  rt_dir_e   dir_q, dir_d;
  logic      wbit_q, wbit_d;
  logic      pulse_d;

  // Phase and pulse-parameter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= 1'b0;
      phase_q  <= PH_SETUP;
      kind_q   <= KIND_SHIFT;
      dir_q    <= RT_FWD;
      wbit_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      kind_q   <= kind_d;
      dir_q    <= dir_d;
      wbit_q   <= wbit_d;
    end
  end

  // Next phase; a new pulse may start straight after HOLD so pulses run back to back
  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    kind_d   = kind_q;
    dir_d    = dir_q;
    wbit_d   = wbit_q;
    done_c   = active_q && (phase_q == PH_HOLD);
    if (!active_q || (phase_q == PH_HOLD)) begin
      active_d = start;
      phase_d  = PH_SETUP;
      if (start) begin
        kind_d = kind;
        dir_d  = dir;
        wbit_d = wbit;
      end
    end else if (phase_q == PH_SETUP) begin
      phase_d = PH_PULSE;
    end else begin
      phase_d = PH_HOLD;
    end
    pulse_d = active_d && (phase_d == PH_PULSE);
  end

  // Pulse lines are flops so the cell currents never see decode glitches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rt_shift <= 1'b0;
      rt_we    <= 1'b0;
      rt_read  <= 1'b0;
    end else begin
      rt_shift <= pulse_d && (kind_d == KIND_SHIFT);
      rt_we    <= pulse_d && (kind_d == KIND_WRITE);
      rt_read  <= pulse_d && (kind_d == KIND_READ);
    end
  end

  assign rt_dir   = 1'(dir_q);
  assign rt_wdata = wbit_q;

endmodule

// File: rtl/rt_track_ctrl.sv
// Racetrack track controller: turns word read/write requests into shift,
// write and read pulse sequences on a ring of N_CELLS cells with one port.
//   clk, rstn        : clock, asynchronous active-low reset
//   bus (slave)      : req/we/addr/wdata in; gnt (comb), rvalid, rdata, busy out
//   pos_o            : logical bit currently under the access port
//   rt_shift_o/rt_dir_o/rt_we_o/rt_wdata_o/rt_read_o : pulse lines to the track
//   rt_rdata_i       : port cell read-out
//   shift_cnt_o      : shift pulse count, present only with RT_SHIFT_CNT_EN
module rt_track_ctrl
  import rt_pkg::*;
#(
  parameter int unsigned N_CELLS = 64,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  rt_track_ctrl_if.slave             bus,
  output logic [$clog2(N_CELLS)-1:0] pos_o,
  output logic                       rt_shift_o,
  output logic                       rt_dir_o,
  output logic                       rt_we_o,
  output logic                       rt_wdata_o,
  output logic                       rt_read_o,
  input  logic                       rt_rdata_i
`ifdef RT_SHIFT_CNT_EN
  ,
  output logic [31:0]                shift_cnt_o
`endif
);

  localparam int unsigned POS_W = $clog2(N_CELLS);
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [POS_W:0] HALF = (POS_W+1)'(N_CELLS / 2);

  rt_state_e         state_q, state_d;
  logic              start_c, gnt_c, seq_done_c, fwd_c;
  rt_kind_e          kind_c;
  rt_dir_e           dir_c, align_dir_q;
  logic              wbit_c;
  logic [POS_W-1:0]  pos_q, tgt_q, tgt_in_c, df_c;
  logic              we_q, rvalid_q, busy_q;
  logic [DATA_W-1:0] wdata_q, rbuf_q, rbuf_nx_c, rdata_q;
  logic [BIT_W-1:0]  bit_q, bit_nx_c;

  // Alignment target and direction for the incoming request (ties go forward)
  assign tgt_in_c = {bus.addr_i, {BIT_W{1'b0}}};
  assign df_c     = tgt_in_c - pos_q;
  assign fwd_c    = ({1'b0, df_c} <= HALF);
  assign bit_nx_c = bit_q + BIT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and next-pulse selection; each new pulse is launched in the HOLD of the last
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    gnt_c   = 1'b0;
    kind_c  = KIND_SHIFT;
    dir_c   = RT_FWD;
    wbit_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          gnt_c   = 1'b1;
          start_c = 1'b1;
          if (df_c == '0) begin
            state_d = ST_ACCESS;
            kind_c  = bus.we_i ? KIND_WRITE : KIND_READ;
            wbit_c  = bus.we_i & bus.wdata_i[0];
          end else begin
            state_d = ST_ALIGN;
            dir_c   = fwd_c ? RT_FWD : RT_BWD;
          end
        end
      end
      ST_ALIGN: begin
        if (seq_done_c) begin
          start_c = 1'b1;
          if (pos_q == tgt_q) begin
            state_d = ST_ACCESS;
            kind_c  = we_q ? KIND_WRITE : KIND_READ;
            wbit_c  = we_q & wdata_q[0];
          end else begin
            dir_c = align_dir_q;
          end
        end
      end
      ST_ACCESS: begin
        if (seq_done_c) begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STEP;
            start_c = 1'b1;
          end
        end
      end
      ST_STEP: begin
        if (seq_done_c) begin
          state_d = ST_ACCESS;
          start_c = 1'b1;
          kind_c  = we_q ? KIND_WRITE : KIND_READ;
          wbit_c  = we_q & wdata_q[bit_nx_c];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read buffer with the port bit merged in at the current position
  always_comb begin
    rbuf_nx_c        = rbuf_q;
    rbuf_nx_c[bit_q] = rt_rdata_i;
  end

  // Request capture, port position tracking and response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q        <= 1'b0;
      wdata_q     <= '0;
      tgt_q       <= '0;
      align_dir_q <= RT_FWD;
      bit_q       <= '0;
      rbuf_q      <= '0;
      rdata_q     <= '0;
      pos_q       <= '0;
      rvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (gnt_c) begin
        we_q        <= bus.we_i;
        wdata_q     <= bus.wdata_i;
        tgt_q       <= tgt_in_c;
        align_dir_q <= fwd_c ? RT_FWD : RT_BWD;
        bit_q       <= '0;
      end
      if ((state_q == ST_STEP) && seq_done_c) bit_q <= bit_nx_c;
      if ((state_q == ST_ACCESS) && seq_done_c && !we_q) begin
        rbuf_q <= rbuf_nx_c;
        if (state_d == ST_DONE) rdata_q <= rbuf_nx_c;
      end
      if (rt_shift_o) pos_q <= rt_dir_o ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
      rvalid_q <= (state_d == ST_DONE);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  rt_pulse_seq u_pulse_seq (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start_c),
    .kind     (kind_c),
    .dir      (dir_c),
    .wbit     (wbit_c),
    .done_c   (seq_done_c),
    .rt_shift (rt_shift_o),
    .rt_dir   (rt_dir_o),
    .rt_we    (rt_we_o),
    .rt_wdata (rt_wdata_o),
    .rt_read  (rt_read_o)
  );

`ifdef RT_SHIFT_CNT_EN
  // Shift pulse counter, wraps at 2^32
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           shift_cnt_o <= '0;
    else if (rt_shift_o) shift_cnt_o <= shift_cnt_o + 32'd1;
  end
`endif

  assign bus.gnt_o    = gnt_c;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.busy_o   = busy_q;
  assign pos_o        = pos_q;

endmodule

// File: tb/tb_rt_track_ctrl.sv
// Directed bench for rt_track_ctrl with a behavioural racetrack model.
module tb_rt_track_ctrl;

  localparam int unsigned N_CELLS = 64;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned POS_W   = 6;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rt_shift, rt_dir, rt_we, rt_wdata, rt_read, rt_rdata;
  logic [POS_W-1:0] pos;
`ifdef RT_SHIFT_CNT_EN
  logic [31:0] shift_cnt;
`endif

  rt_track_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rt_track_ctrl #(.N_CELLS(N_CELLS), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .pos_o      (pos),
    .rt_shift_o (rt_shift),
    .rt_dir_o   (rt_dir),
    .rt_we_o    (rt_we),
    .rt_wdata_o (rt_wdata),
    .rt_read_o  (rt_read),
    .rt_rdata_i (rt_rdata)
`ifdef RT_SHIFT_CNT_EN
    ,
    .shift_cnt_o(shift_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Track model: cells move under the port as shift pulses arrive
  logic [N_CELLS-1:0] cells;
  logic [POS_W-1:0]   mpos;
  logic [4:0]         cur, h1, h2;
  int hv = 0;
  int fwd_cnt = 0, bwd_cnt = 0, we_cnt = 0, tot_shift = 0;

  assign rt_rdata = cells[mpos];

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      cells     = '0;
      mpos      = '0;
      tot_shift = 0;
      hv        = 0;
    end else begin
      cur = {rt_shift, rt_we, rt_read, rt_dir, rt_wdata};
      // h2 = SETUP, h1 = PULSE, cur = HOLD
      if (hv >= 2 && h1[4:2] != 3'b000) begin
        chk("pulse_onehot", $countones(h1[4:2]), 1);
        chk("pulse_setup_low", 32'(h2[4:2]), 0);
        chk("pulse_hold_low", 32'(cur[4:2]), 0);
        chk("pulse_dir_wdata_stable", {h2[1:0], h1[1:0]}, {cur[1:0], cur[1:0]});
      end
      h2 = h1;
      h1 = cur;
      if (hv < 2) hv++;
      if (rt_we) begin
        cells[mpos] = rt_wdata;
        we_cnt++;
      end
      if (rt_shift) begin
        tot_shift++;
        if (rt_dir) begin
          mpos = mpos - 6'd1;
          bwd_cnt++;
        end else begin
          mpos = mpos + 6'd1;
          fwd_cnt++;
        end
      end
    end
  end

  task automatic do_op(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] wd,
                       input logic hold_req, output logic [7:0] rd, output int lat, output int xgnt);
    lat = 0;
    xgnt = 0;
    rd = '0;
    fwd_cnt = 0;
    bwd_cnt = 0;
    we_cnt = 0;
    @(negedge clk);
    bus.req_i = 1'b1;
    bus.we_i = we;
    bus.addr_i = a;
    bus.wdata_i = wd;
    #1 chk("gnt_on_request", 32'(bus.gnt_o), 1);
    @(posedge clk);
    #1;
    if (!hold_req) bus.req_i = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (bus.gnt_o) xgnt++;
      if (bus.rvalid_o) begin
        lat = c;
        rd = bus.rdata_o;
        break;
      end
    end
    bus.req_i = 1'b0;
    if (lat == 0) chk("op_timeout", 0, 1);
  endtask

  task automatic run_op(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [7:0] wd, input logic hold_req, input logic [7:0] exp_rd,
                        input int exp_lat, input int exp_pos, input int exp_fwd, input int exp_bwd);
    logic [7:0] rd;
    int lat, xgnt;
    do_op(we, a, wd, hold_req, rd, lat, xgnt);
    chk($sformatf("%s_latency", tag), lat, exp_lat);
    chk($sformatf("%s_rdata", tag), 32'(rd), 32'(exp_rd));
    chk($sformatf("%s_pos", tag), 32'(pos), exp_pos);
    chk($sformatf("%s_fwd_pulses", tag), fwd_cnt, exp_fwd);
    chk($sformatf("%s_bwd_pulses", tag), bwd_cnt, exp_bwd);
    chk($sformatf("%s_extra_gnt", tag), xgnt, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk($sformatf("%s_pos", tag), 32'(pos), 0);
    chk($sformatf("%s_busy", tag), 32'(bus.busy_o), 0);
    chk($sformatf("%s_rvalid", tag), 32'(bus.rvalid_o), 0);
    chk($sformatf("%s_rdata", tag), 32'(bus.rdata_o), 0);
    chk($sformatf("%s_lines", tag), 32'({rt_shift, rt_dir, rt_we, rt_wdata, rt_read}), 0);
  endtask

  initial begin
    int seen;
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.addr_i = '0;
    bus.wdata_i = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset_gnt_idle", 32'(bus.gnt_o), 0);
    rstn = 1'b1;

    //      tag         we    a     wd     hold  rd     lat  pos fwd bwd
    run_op("wr_a0",    1'b1, 3'd0, 8'hA5, 1'b0, 8'h00,  46,  7,  7,  0);
    run_op("rd_a0",    1'b0, 3'd0, 8'h00, 1'b0, 8'hA5,  67,  7,  7,  7);
    run_op("wr_a1",    1'b1, 3'd1, 8'h3C, 1'b0, 8'hA5,  49, 15,  8,  0);
    run_op("rd_a1",    1'b0, 3'd1, 8'h00, 1'b0, 8'h3C,  67, 15,  7,  7);
    run_op("rd_a0_b",  1'b0, 3'd0, 8'h00, 1'b0, 8'hA5,  91,  7,  7, 15);
    run_op("rd_a6",    1'b0, 3'd6, 8'h00, 1'b0, 8'h00, 115, 55,  7, 23);

    // Reset during bit 3 of a write
    we_cnt = 0;
    @(negedge clk);
    bus.req_i = 1'b1;
    bus.we_i = 1'b1;
    bus.addr_i = 3'd0;
    bus.wdata_i = 8'hFF;
    @(posedge clk);
    #1 bus.req_i = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (we_cnt >= 4) break;
    end
    chk("midrst_reached_bit3", 32'(we_cnt >= 4), 1);
    #2 rstn = 1'b0;
    #1 chk_quiet("midrst");
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rvalid_o) seen = 1;
    end
    rstn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.rvalid_o) seen = 1;
    end
    chk("midrst_no_rvalid", seen, 0);
    chk("midrst_idle", 32'(bus.busy_o), 0);
    run_op("rd_a0_rst", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00,  46,  7,  7,  0);

    // Clean reset, then tie case with req held through the whole access
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_op("rd_a4_tie", 1'b0, 3'd4, 8'h00, 1'b1, 8'h00, 142, 39, 39,  0);
    run_op("wr_a4",     1'b1, 3'd4, 8'h5A, 1'b0, 8'h00,  67, 39,  7,  7);
    run_op("rd_a4",     1'b0, 3'd4, 8'h00, 1'b0, 8'h5A,  67, 39,  7,  7);

`ifdef RT_SHIFT_CNT_EN
    chk("shift_cnt", shift_cnt, tot_shift);
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
